sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 20 ++
 rtl/sram_arbiter_rr_arb2.sv | 32 +++
 rtl/sram_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the SRAM slot arbiter.
// Phase values are one-hot so they can be driven straight onto the phase port.
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 15;

  typedef enum logic [3:0] {
    P0 = 4'b0001,
    P1 = 4'b0010,
    P2 = 4'b0100,
    P3 = 4'b1000
  } phase_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_CAM = 1'b1
  } req_e;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way winner selection between the CPU and camera ports.
// Defining SRAM_ARB_FIXED_PRIO_EN gives ties to the camera; otherwise ties alternate.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic cam_req_i,
  input  req_e last_winner_i,
  output logic any_o,
  output req_e winner_o
);

  always_comb begin
    any_o    = cpu_req_i | cam_req_i;
    winner_o = REQ_CPU;
    if (cam_req_i && !cpu_req_i) begin
      winner_o = REQ_CAM;
    end else if (cam_req_i && cpu_req_i) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      winner_o = REQ_CAM;
`else
      winner_o = (last_winner_i == REQ_CPU) ? REQ_CAM : REQ_CPU;
`endif
    end
  end

`ifdef SRAM_ARB_FIXED_PRIO_EN
  logic last_winner_unused;
  assign last_winner_unused = (last_winner_i == REQ_CAM);
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Four-phase SRAM time-slot arbiter: display read in P1/P2, one CPU/camera access in P3/P0.
// Build option: SRAM_ARB_FIXED_PRIO_EN (camera always wins ties).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock_100m,
  input  logic              reset_100m_n,
  output logic [3:0]        phase,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              cam_req,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_wdata,
  output logic              cam_gnt,
  output logic [DATA_W-1:0] cam_rdata,
  output logic              cam_rvalid,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              SRAM_CE_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_UB_N
);

  phase_e            phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              cam_gnt_q, cam_gnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] cam_rdata_q, cam_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              cam_rvalid_q, cam_rvalid_d;
  req_e              last_q, last_d;
  logic              pend_q, pend_d;
  logic              pend_we_q, pend_we_d;
  req_e              pend_who_q, pend_who_d;

  logic              arb_any;
  req_e              arb_win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              dq_in_unused;

  rr_arb2 u_arb (
    .cpu_req_i     (cpu_req),
    .cam_req_i     (cam_req),
    .last_winner_i (last_q),
    .any_o         (arb_any),
    .winner_o      (arb_win)
  );

  assign win_we    = (arb_win == REQ_CAM) ? cam_we    : cpu_we;
  assign win_addr  = (arb_win == REQ_CAM) ? cam_addr  : cpu_addr;
  assign win_wdata = (arb_win == REQ_CAM) ? cam_wdata : cpu_wdata;

  always_comb begin
    case (phase_q)
      P0:      phase_d = P1;
      P1:      phase_d = P2;
      P2:      phase_d = P3;
      P3:      phase_d = P0;
      default: phase_d = P0;
    endcase
  end

  always_ff @(posedge clock_100m or negedge reset_100m_n) begin
    if (!reset_100m_n) phase_q <= P0;
    else               phase_q <= phase_d;
  end

  always_comb begin
    addr_d       = addr_q;
    we_n_d       = we_n_q;
    oe_n_d       = oe_n_q;
    dq_out_d     = dq_out_q;
    dq_oe_d      = dq_oe_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    cpu_gnt_d    = 1'b0;
    cam_gnt_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    cam_rdata_d  = cam_rdata_q;
    cpu_rvalid_d = 1'b0;
    cam_rvalid_d = 1'b0;
    last_d       = last_q;
    pend_d       = pend_q;
    pend_we_d    = pend_we_q;
    pend_who_d   = pend_who_q;
    case (phase_q)
      P0: begin
        // Retire the P3/P0 access and hand the bus back to the display read.
        addr_d  = disp_addr;
        oe_n_d  = 1'b0;
        dq_oe_d = 1'b0;
        we_n_d  = 1'b1;
        pend_d  = 1'b0;
        if (pend_q && !pend_we_q) begin
          if (pend_who_q == REQ_CPU) begin
            cpu_rvalid_d = 1'b1;
            cpu_rdata_d  = sram_dq_in[DATA_W-1:0];
          end else begin
            cam_rvalid_d = 1'b1;
            cam_rdata_d  = sram_dq_in[DATA_W-1:0];
          end
        end
      end
      P2: begin
        disp_data_d  = sram_dq_in[DATA_W-1:0];
        disp_valid_d = 1'b1;
        if (arb_any) begin
          addr_d     = win_addr;
          last_d     = arb_win;
          pend_d     = 1'b1;
          pend_we_d  = win_we;
          pend_who_d = arb_win;
          cpu_gnt_d  = (arb_win == REQ_CPU);
          cam_gnt_d  = (arb_win == REQ_CAM);
          if (win_we) begin
            oe_n_d               = 1'b1;
            dq_oe_d              = 1'b1;
            dq_out_d             = '0;
            dq_out_d[DATA_W-1:0] = win_wdata;
          end
        end
      end
      P3: begin
        if (pend_q && pend_we_q) we_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_100m or negedge reset_100m_n) begin
    if (!reset_100m_n) begin
      addr_q       <= '0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      cam_gnt_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      cam_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      cam_rvalid_q <= 1'b0;
      last_q       <= REQ_CAM;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_who_q   <= REQ_CPU;
    end else begin
      addr_q       <= addr_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      cpu_gnt_q    <= cpu_gnt_d;
      cam_gnt_q    <= cam_gnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cam_rdata_q  <= cam_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cam_rvalid_q <= cam_rvalid_d;
      last_q       <= last_d;
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_who_q   <= pend_who_d;
    end
  end

  assign dq_in_unused = ^sram_dq_in;

  assign phase       = phase_q;
  assign disp_data   = disp_data_q;
  assign disp_valid  = disp_valid_q;
  assign cpu_gnt     = cpu_gnt_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign cam_gnt     = cam_gnt_q;
  assign cam_rdata   = cam_rdata_q;
  assign cam_rvalid  = cam_rvalid_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign SRAM_CE_N   = 1'b0;
  assign SRAM_LB_N   = 1'b0;
  assign SRAM_UB_N   = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, display slot, CPU write, camera read,
// contention ordering and reset during a write.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  phase;
  logic [19:0] disp_addr;
  logic [14:0] disp_data;
  logic        disp_valid;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [19:0] cpu_addr;
  logic [14:0] cpu_wdata, cpu_rdata;
  logic        cam_req, cam_we, cam_gnt, cam_rvalid;
  logic [19:0] cam_addr;
  logic [14:0] cam_wdata, cam_rdata;
  logic [19:0] sram_addr;
  logic        we_n, oe_n, dq_oe, ce_n, lb_n, ub_n;
  logic [15:0] dq_out, dq_in;

  int checks = 0;
  int errors = 0;
  int exp_ph = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(20), .DATA_W(15)) dut (
    .clock_100m(clk), .reset_100m_n(rst_n), .phase(phase),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cam_req(cam_req), .cam_we(cam_we), .cam_addr(cam_addr), .cam_wdata(cam_wdata),
    .cam_gnt(cam_gnt), .cam_rdata(cam_rdata), .cam_rvalid(cam_rvalid),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .sram_dq_out(dq_out), .sram_dq_oe(dq_oe), .sram_dq_in(dq_in),
    .SRAM_CE_N(ce_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
  );

  // Advance one clock, sample 1ns later, and check the phase rotation and
  // that no write drive overlaps the display read slots.
  task automatic step();
    logic [3:0] want_ph;
    @(posedge clk);
    #1;
    exp_ph  = (exp_ph + 1) % 4;
    want_ph = 4'b0001 << exp_ph;
    checks++;
    if (phase !== want_ph) begin
      errors++;
      $display("FAIL phase got=%b want=%b", phase, want_ph);
    end
    if (exp_ph == 1 || exp_ph == 2) begin
      checks++;
      if (we_n !== 1'b1 || dq_oe !== 1'b0) begin
        errors++;
        $display("FAIL disp_slot_quiet P%0d we_n=%b dq_oe=%b want we_n=1 dq_oe=0", exp_ph, we_n, dq_oe);
      end
    end
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 4 && exp_ph != p; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    {cpu_req, cpu_we, cam_req, cam_we} = '0;
    cpu_addr = '0; cpu_wdata = '0; cam_addr = '0; cam_wdata = '0;
    disp_addr = 20'h00005;
    dq_in = 16'h7FFF;
    #2 rst_n = 1'b0;
    #21;
    checks++;
    if (phase !== 4'b0001) begin errors++; $display("FAIL rst_phase got=%b want=0001", phase); end
    checks++;
    if ({we_n, oe_n, dq_oe} !== 3'b110) begin
      errors++; $display("FAIL rst_ctrl got we/oe/dqoe=%b want=110", {we_n, oe_n, dq_oe});
    end
    checks++;
    if (sram_addr !== 20'h0 || dq_out !== 16'h0) begin
      errors++; $display("FAIL rst_bus got addr=%h dq_out=%h want 0 0", sram_addr, dq_out);
    end
    checks++;
    if ({cpu_gnt, cam_gnt, cpu_rvalid, cam_rvalid, disp_valid} !== 5'b0) begin
      errors++; $display("FAIL rst_strobes got=%b want=00000", {cpu_gnt, cam_gnt, cpu_rvalid, cam_rvalid, disp_valid});
    end
    checks++;
    if (cpu_rdata !== 15'h0 || cam_rdata !== 15'h0 || disp_data !== 15'h0) begin
      errors++; $display("FAIL rst_data got %h %h %h want 0 0 0", cpu_rdata, cam_rdata, disp_data);
    end
    checks++;
    if ({ce_n, lb_n, ub_n} !== 3'b000) begin
      errors++; $display("FAIL const_enables got=%b want=000", {ce_n, lb_n, ub_n});
    end
    rst_n  = 1'b1;
    exp_ph = 0;
    step();
  endtask

  task automatic test_display();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      checks++;
      if (disp_valid !== (exp_ph == 3)) begin
        errors++; $display("FAIL disp_valid P%0d got=%b want=%b", exp_ph, disp_valid, exp_ph == 3);
      end
      checks++;
      if (we_n !== 1'b1) begin errors++; $display("FAIL disp_we_n P%0d got=%b want=1", exp_ph, we_n); end
      if (exp_ph == 3) begin
        checks++;
        if (disp_data !== 15'h7FFF) begin errors++; $display("FAIL disp_data got=%h want=7fff", disp_data); end
      end
      if (exp_ph == 1 || exp_ph == 2) begin
        checks++;
        if (sram_addr !== 20'h00005 || oe_n !== 1'b0) begin
          errors++; $display("FAIL disp_bus got addr=%h oe_n=%b want 00005 0", sram_addr, oe_n);
        end
      end
    end
  endtask

  task automatic test_cpu_write();
    int lat;
    wait_ph(0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h0A00C; cpu_wdata = 15'h1234;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      step(); lat++;
      if (cpu_gnt === 1'b1) break;
    end
    checks++;
    if (cpu_gnt !== 1'b1 || lat != 3) begin
      errors++; $display("FAIL cpu_gnt_latency got gnt=%b after %0d want gnt=1 after 3", cpu_gnt, lat);
    end
    checks++;
    if (sram_addr !== 20'h0A00C || dq_out !== 16'h1234 || dq_oe !== 1'b1 || oe_n !== 1'b1 || we_n !== 1'b1) begin
      errors++; $display("FAIL cpu_wr_p3 got addr=%h dq=%h dqoe=%b oe_n=%b we_n=%b want 0a00c 1234 1 1 1",
                         sram_addr, dq_out, dq_oe, oe_n, we_n);
    end
    cpu_req = 1'b0;
    step();
    checks++;
    if (we_n !== 1'b0 || dq_oe !== 1'b1 || cpu_gnt !== 1'b0 || sram_addr !== 20'h0A00C) begin
      errors++; $display("FAIL cpu_wr_p0 got we_n=%b dqoe=%b gnt=%b addr=%h want 0 1 0 0a00c",
                         we_n, dq_oe, cpu_gnt, sram_addr);
    end
    step();
    checks++;
    if (oe_n !== 1'b0 || sram_addr !== 20'h00005) begin
      errors++; $display("FAIL cpu_wr_p1 got oe_n=%b addr=%h want 0 00005", oe_n, sram_addr);
    end
    step(); step();
    checks++;
    if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL cpu_single_gnt got=%b want=0", cpu_gnt); end
  endtask

  task automatic test_cam_read();
    int lat;
    cam_req = 1'b1; cam_we = 1'b0; cam_addr = 20'h00100; dq_in = 16'h0ABC;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      step(); lat++;
      checks++;
      if (oe_n !== 1'b0) begin errors++; $display("FAIL cam_oe_n_wait got=%b want=0", oe_n); end
      if (cam_gnt === 1'b1) break;
    end
    checks++;
    if (cam_gnt !== 1'b1 || lat != 4) begin
      errors++; $display("FAIL cam_gnt_latency got gnt=%b after %0d want gnt=1 after 4", cam_gnt, lat);
    end
    checks++;
    if (sram_addr !== 20'h00100 || dq_oe !== 1'b0 || cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL cam_rd_p3 got addr=%h dqoe=%b cpu_gnt=%b want 00100 0 0", sram_addr, dq_oe, cpu_gnt);
    end
    cam_req = 1'b0;
    step();
    checks++;
    if (oe_n !== 1'b0 || we_n !== 1'b1 || cam_rvalid !== 1'b0) begin
      errors++; $display("FAIL cam_rd_p0 got oe_n=%b we_n=%b rvalid=%b want 0 1 0", oe_n, we_n, cam_rvalid);
    end
    step();
    checks++;
    if (cam_rvalid !== 1'b1 || cam_rdata !== 15'h0ABC || cpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL cam_rd_p1 got rvalid=%b rdata=%h cpu_rvalid=%b want 1 0abc 0",
                         cam_rvalid, cam_rdata, cpu_rvalid);
    end
    step();
    checks++;
    if (cam_rvalid !== 1'b0) begin errors++; $display("FAIL cam_rvalid_len got=%b want=0", cam_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic want_cpu;
    wait_ph(0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00ABC; cpu_wdata = 15'h2AAA;
    cam_req = 1'b1; cam_we = 1'b0; cam_addr = 20'h00100;
    for (int s = 0; s < 4; s++) begin
      wait_ph(3);
`ifdef SRAM_ARB_FIXED_PRIO_EN
      want_cpu = 1'b0;
`else
      want_cpu = (s % 2 == 0);
`endif
      checks++;
      if ({cpu_gnt, cam_gnt} !== {want_cpu, ~want_cpu}) begin
        errors++; $display("FAIL tie_slot%0d got cpu/cam=%b want=%b", s, {cpu_gnt, cam_gnt}, {want_cpu, ~want_cpu});
      end
      checks++;
      if (sram_addr !== (want_cpu ? 20'h00ABC : 20'h00100)) begin
        errors++; $display("FAIL tie_addr%0d got=%h want=%h", s, sram_addr, want_cpu ? 20'h00ABC : 20'h00100);
      end
      step();
      checks++;
      if (we_n !== ~want_cpu) begin
        errors++; $display("FAIL tie_we_n%0d got=%b want=%b", s, we_n, ~want_cpu);
      end
    end
    cpu_req = 1'b0; cam_req = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int lat;
    wait_ph(0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00777; cpu_wdata = 15'h0555;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      step(); lat++;
      if (cpu_gnt === 1'b1) break;
    end
    checks++;
    if (cpu_gnt !== 1'b1 || lat != 3) begin
      errors++; $display("FAIL rstw_gnt got gnt=%b after %0d want gnt=1 after 3", cpu_gnt, lat);
    end
    cpu_req = 1'b0;
    step();
    checks++;
    if (we_n !== 1'b0) begin errors++; $display("FAIL rstw_pre_we_n got=%b want=0", we_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (we_n !== 1'b1 || dq_oe !== 1'b0 || phase !== 4'b0001 || cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL rstw_abort got we_n=%b dqoe=%b phase=%b gnt=%b want 1 0 0001 0",
                         we_n, dq_oe, phase, cpu_gnt);
    end
    #2 rst_n = 1'b1;
    exp_ph = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cpu_gnt !== 1'b0 || cam_gnt !== 1'b0 || we_n !== 1'b1) begin
        errors++; $display("FAIL rstw_no_reissue P%0d got gnt=%b%b we_n=%b want 00 1", exp_ph, cpu_gnt, cam_gnt, we_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_cpu_write();
    test_cam_read();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
